midi_rx_arb: RTL
================

# midi_rx_arb

Round-robin arbiter that merges the byte outputs of N_CH uart_rx receivers into the single write port of the MIDI ingress FIFO. Each channel's completed byte is captured into a per-channel holding register on the rising edge of its uart_data_rdy. Pending bytes are written to the FIFO tagged with the source channel number. The block sits between the uart_rx instances and the ingress FIFO, on the same system clock as the receivers.

## Interface

- N_CH, 4, number of receive channels; legal values 2, 4, 8
- CW, $clog2(N_CH), channel-tag width; derived, not overridden
- clk  in  1  system clock; the same clock that drives clk_en_gen and uart_rx
- reset  in  1  asynchronous, active-high; clears all state
- uart_data  in  8*N_CH  channel c byte on bits [8c+7:8c]
- uart_data_rdy  in  N_CH  per-channel ready level from uart_rx; only rising edges are significant
- fifo_full  in  1  ingress FIFO full
- fifo_wr  out  1  one-cycle write strobe to the FIFO
- fifo_dat  out  8+CW  {channel[CW-1:0], byte[7:0]}
- pending  out  N_CH  holding register c is occupied
- overrun  out  N_CH  sticky flag: channel c byte dropped
- ovr_clr  in  N_CH  per-channel clear pulse for overrun

## Operation

- Edge detect:
  - rdy_q[c] registers uart_data_rdy[c] every clk.
  - rise[c] = uart_data_rdy[c] & ~rdy_q[c].
  - No clk_en gating; detection runs at the full clk rate.
- Capture:
  - On rise[c] with pending[c]=0, or with pending[c] being cleared this same edge, hold[c] <= uart_data[c] and pending[c] <= 1.
  - On rise[c] with pending[c]=1 and not being cleared: hold[c] keeps the old byte, the new byte is dropped, and overrun[c] <= 1.
- Overrun clear:
  - ovr_clr[c] clears overrun[c].
  - If a set and ovr_clr[c] occur on the same edge, the set wins.
- FSM, two states:
  - IDLE: if any pending and fifo_full=0, select the first pending channel scanning upward from ptr, with wrap from N_CH-1 to 0. Register sel, and fifo_dat <= {sel, hold[sel]}. Go to WRITE. Otherwise stay in IDLE.
  - WRITE: fifo_wr=1 (decoded from state). On the exit edge: pending[sel] <= 0 (subject to the capture rule above), ptr <= sel+1 mod N_CH, go to IDLE.
- fifo_full:
  - Sampled only in IDLE.
  - A WRITE, once entered, always completes. This block is the FIFO's only writer, so the FIFO cannot fill between the check and the write.
- Fairness: ptr advances past the last served channel. A channel with a byte pending is served within N_CH writes.

## Timing

- Reset values:
  - fifo_wr=0, fifo_dat=0, pending=0, overrun=0.
  - State IDLE, ptr=0, rdy_q=0, hold=0.
- Latency: rise[c] sampled at edge k sets pending after k. IDLE grants at edge k+1. fifo_wr is high during cycle k+1..k+2 and the FIFO captures at edge k+2. pending[c] is clear after k+2.
- Throughput: one FIFO write per 2 clk. Minimum byte spacing per channel is 80 clk (10 bits × 8 clk_en_8 periods), so overrun occurs only if the FIFO stays full.
- fifo_dat is stable for the whole cycle in which fifo_wr=1, and holds its last value otherwise.
- Reset asserted mid-WRITE: fifo_wr drops asynchronously and the in-flight byte is lost.
- A rise on channel sel during its own WRITE exit edge is a new capture, not an overrun.

## Test plan

- Single byte: ch0 rdy rises with 0xDE -> fifo_wr for exactly one cycle, 2 clk after the sampling edge, with fifo_dat = {0,0xDE} (for N_CH=4, 10'h0DE). pending returns to 0.
- Simultaneous rises: ch0=0x11, ch1=0x22, ch2=0x33, ch3=0x44 on the same edge, ptr=0 -> writes in order ch0, ch1, ch2, ch3 on alternating cycles. Next simultaneous burst is served starting at ch0 again (ptr wrapped 3->0).
- Full backpressure: fifo_full=1 while ch2 receives 0x55, then ch2 receives 0x66 -> no fifo_wr, pending[2]=1, overrun[2]=1. Release full -> exactly one write of {2,0x55}.
- Overrun clear race: ovr_clr[2] on the same edge as a new overrun on ch2 -> overrun[2] stays 1. ovr_clr[2] alone -> overrun[2]=0.
- Capture during write: ch1 rise on the WRITE exit edge for ch1 -> pending[1] stays 1, no overrun, second byte written next.
- Async reset with WRITE active -> all outputs at reset values before the next clk edge, and no fifo_wr after reset release.

Source files
------------

// File: rtl/midi_rx_arb.sv
// midi_rx_arb
// Merges the byte outputs of N_CH uart_rx receivers into the single write
// port of the MIDI ingress FIFO. Each completed byte is captured into a
// per-channel holding register on the rising edge of its ready level, then
// written to the FIFO tagged with its channel number. Pending channels are
// served round-robin.
//
// Ports:
//   clk            system clock shared with the receivers
//   reset          asynchronous active-high reset, clears all state
//   uart_data      channel c byte on bits [8c+7:8c]
//   uart_data_rdy  per-channel ready level; only rising edges matter
//   fifo_full      ingress FIFO full, sampled only while idle
//   fifo_wr        one-cycle FIFO write strobe
//   fifo_dat       {channel, byte} presented with fifo_wr
//   pending        holding register c is occupied
//   overrun        sticky: a byte on channel c was dropped
//   ovr_clr        per-channel clear pulse for overrun
module midi_rx_arb #(
   parameter int N_CH = 4,
   localparam int CW = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [8*N_CH-1:0] uart_data,
   input  logic [N_CH-1:0]   uart_data_rdy,
   input  logic              fifo_full,
   output logic              fifo_wr,
   output logic [8+CW-1:0]   fifo_dat,
   output logic [N_CH-1:0]   pending,
   output logic [N_CH-1:0]   overrun,
   input  logic [N_CH-1:0]   ovr_clr
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [N_CH-1:0] rdy_q;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] clr;
   logic [N_CH-1:0] capture;
   logic [N_CH-1:0] pending_next;
   logic [N_CH-1:0] overrun_next;
   logic [7:0]      hold [N_CH];
   logic [CW-1:0]   ptr;
   logic [CW-1:0]   sel;
   logic [CW-1:0]   pick;
   logic [CW-1:0]   scan_idx;
   logic            found;
   logic            grant;

   assign rise    = uart_data_rdy & ~rdy_q;
   // A holding register being emptied on this edge may accept a new byte,
   // so a rise during the write exit edge is a capture, never an overrun.
   assign capture = rise & (~pending | clr);
   assign pending_next = capture | (pending & ~clr);
   // Set has priority over clear when both land on the same edge.
   assign overrun_next = (rise & ~capture) | (overrun & ~ovr_clr);
   assign fifo_wr  = (state == WRITE);

   // Decode which holding register is being emptied on this edge.
   always_comb begin
      clr = '0;
      for (int c = 0; c < N_CH; c++) begin
         if ((state == WRITE) && (sel == CW'(c))) begin
            clr[c] = 1'b1;
         end else begin
            clr[c] = 1'b0;
         end
      end
   end

   // Round-robin scan: first pending channel at or above ptr, wrapping.
   // N_CH is a power of two, so CW-bit addition wraps naturally.
   always_comb begin
      found    = 1'b0;
      pick     = ptr;
      scan_idx = ptr;
      for (int i = 0; i < N_CH; i++) begin
         scan_idx = ptr + CW'(i);
         if (!found && pending[scan_idx]) begin
            found = 1'b1;
            pick  = scan_idx;
         end else begin
            found = found;
         end
      end
   end

   // Next-state logic; fifo_full is only consulted in IDLE so a started
   // write always completes.
   always_comb begin
      state_next = state;
      grant      = 1'b0;
      case (state)
         IDLE: begin
            if (found && !fifo_full) begin
               grant      = 1'b1;
               state_next = WRITE;
            end else begin
               state_next = IDLE;
            end
         end
         WRITE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, edge detect, holding registers, flags and FIFO data register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         rdy_q    <= '0;
         pending  <= '0;
         overrun  <= '0;
         ptr      <= '0;
         sel      <= '0;
         fifo_dat <= '0;
         for (int c = 0; c < N_CH; c++) begin
            hold[c] <= 8'h00;
         end
      end else begin
         state   <= state_next;
         rdy_q   <= uart_data_rdy;
         pending <= pending_next;
         overrun <= overrun_next;
         for (int c = 0; c < N_CH; c++) begin
            if (capture[c]) begin
               hold[c] <= uart_data[8*c +: 8];
            end else begin
               hold[c] <= hold[c];
            end
         end
         if (grant) begin
            sel      <= pick;
            fifo_dat <= {pick, hold[pick]};
         end else begin
            sel      <= sel;
            fifo_dat <= fifo_dat;
         end
         if (state == WRITE) begin
            ptr <= sel + CW'(1);
         end else begin
            ptr <= ptr;
         end
      end
   end

endmodule
